// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce
// Input conditioning for the GPIO pads: two-flop synchroniser per bit, a shared
// sample-tick prescaler, and a per-channel stability counter that accepts a new
// level only after it has been seen on STABLE_TICKS consecutive ticks. Accepted
// changes are presented as a registered level plus one-cycle rise/fall pulses.

module gpio_in_debounce #(
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 100,
    parameter int STABLE_TICKS = 4
) (
    input  logic             clk_sys_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] gpio_pad_i,
    output logic [WIDTH-1:0] gpio_in_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // Prescaler width never drops below one bit so PRESCALE=1 still elaborates.
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CNT_W = ($clog2(STABLE_TICKS + 1) > 0) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [PS_W-1:0]  ps_cnt;
    logic             tick;
    logic [CNT_W-1:0] cnt [WIDTH];

    // Two-flop synchroniser; only sync2 is consumed downstream.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_pad_i;
            sync2 <= sync1;
        end
    end

    // Shared sample prescaler: 0..PRESCALE-1 then wrap. With PRESCALE=1 the
    // terminal value is 0, so the counter sits at 0 and tick stays high.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ps_cnt <= '0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    assign tick = (ps_cnt == PS_LAST);

    // Per-channel qualification: a level differing from the accepted one must
    // be seen on STABLE_TICKS consecutive ticks; any tick back at the accepted
    // level restarts the count. Pulses default low every cycle.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            gpio_in_o <= '0;
            rise_o    <= '0;
            fall_o    <= '0;
        end else begin
            rise_o <= '0;
            fall_o <= '0;
            if (tick) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync2[i] == gpio_in_o[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        cnt[i]       <= '0;
                        gpio_in_o[i] <= sync2[i];
                        rise_o[i]    <= sync2[i];
                        fall_o[i]    <= ~sync2[i];
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce: two instances (PRESCALE=1/STABLE_TICKS=4 and
// PRESCALE=10/STABLE_TICKS=3) share pad and reset. A reference model keeps the
// last two pad samples and the last STABLE_TICKS tick samples, and accepts a
// new level when every sample in that window disagrees with the accepted one.

module tb_gpio_in_debounce;

    logic       clk_sys_i;
    logic       rst_n_i;
    logic [7:0] pad;
    logic [7:0] gin_a, rise_a, fall_a;
    logic [7:0] gin_b, rise_b, fall_b;

    int total = 0;
    int bad   = 0;

    gpio_in_debounce #(.WIDTH(8), .PRESCALE(1), .STABLE_TICKS(4)) dut_a (
        .clk_sys_i  (clk_sys_i),
        .rst_n_i    (rst_n_i),
        .gpio_pad_i (pad),
        .gpio_in_o  (gin_a),
        .rise_o     (rise_a),
        .fall_o     (fall_a)
    );

    gpio_in_debounce #(.WIDTH(8), .PRESCALE(10), .STABLE_TICKS(3)) dut_b (
        .clk_sys_i  (clk_sys_i),
        .rst_n_i    (rst_n_i),
        .gpio_pad_i (pad),
        .gpio_in_o  (gin_b),
        .rise_o     (rise_b),
        .fall_o     (fall_b)
    );

    initial clk_sys_i = 1'b0;
    always #5 clk_sys_i = ~clk_sys_i;

    // Reference model, one per instance.
    for (genvar m = 0; m < 2; m++) begin : g_ref
        localparam int P = (m == 0) ? 1 : 10;
        localparam int S = (m == 0) ? 4 : 3;
        int unsigned edge_cnt;
        logic [7:0]  pad_q[$];
        logic [7:0]  tick_q[$];
        logic [7:0]  seen;
        logic        all_new;
        logic [7:0]  exp_lvl, exp_rise, exp_fall;

        always @(posedge clk_sys_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                edge_cnt = 0;
                pad_q.delete();
                tick_q.delete();
                exp_lvl  = '0;
                exp_rise = '0;
                exp_fall = '0;
            end else begin
                edge_cnt++;
                seen = (pad_q.size() == 2) ? pad_q[0] : 8'h00;
                pad_q.push_back(pad);
                if (pad_q.size() > 2) void'(pad_q.pop_front());
                exp_rise = '0;
                exp_fall = '0;
                if (edge_cnt % P == 0) begin
                    tick_q.push_back(seen);
                    if (tick_q.size() > S) void'(tick_q.pop_front());
                    if (tick_q.size() == S) begin
                        for (int i = 0; i < 8; i++) begin
                            all_new = 1'b1;
                            for (int j = 0; j < S; j++)
                                if (tick_q[j][i] == exp_lvl[i]) all_new = 1'b0;
                            if (all_new) begin
                                exp_lvl[i] = ~exp_lvl[i];
                                if (exp_lvl[i]) exp_rise[i] = 1'b1;
                                else            exp_fall[i] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare both instances against the model after the edge, then drive the next pad value.
    task automatic cyc(input logic [7:0] nxt);
        @(posedge clk_sys_i);
        #1;
        chk("a_lvl",  {24'h0, gin_a},  {24'h0, g_ref[0].exp_lvl});
        chk("a_rise", {24'h0, rise_a}, {24'h0, g_ref[0].exp_rise});
        chk("a_fall", {24'h0, fall_a}, {24'h0, g_ref[0].exp_fall});
        chk("b_lvl",  {24'h0, gin_b},  {24'h0, g_ref[1].exp_lvl});
        chk("b_rise", {24'h0, rise_b}, {24'h0, g_ref[1].exp_rise});
        chk("b_fall", {24'h0, fall_b}, {24'h0, g_ref[1].exp_fall});
        chk("a_excl", {24'h0, rise_a & fall_a}, 32'h0);
        chk("b_excl", {24'h0, rise_b & fall_b}, 32'h0);
        pad = nxt;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gin_a"},  {24'h0, gin_a},  32'h0);
        chk({tag, "_rise_a"}, {24'h0, rise_a}, 32'h0);
        chk({tag, "_fall_a"}, {24'h0, fall_a}, 32'h0);
        chk({tag, "_gin_b"},  {24'h0, gin_b},  32'h0);
        chk({tag, "_rise_b"}, {24'h0, rise_b}, 32'h0);
        chk({tag, "_fall_b"}, {24'h0, fall_b}, 32'h0);
    endtask

    initial begin
        logic [7:0] v;
        int         hold;
        int         pulses;
        int         pulse_edge;

        rst_n_i = 1'b0;
        pad     = 8'hFF;
        #3;
        check_all_zero("rst");
        @(posedge clk_sys_i);
        #1;
        rst_n_i = 1'b1;

        // Pad held high through reset: accepted on edge 6 for the fast instance.
        repeat (5) cyc(8'hFF);
        chk("rel_e5_lvl", {24'h0, gin_a}, 32'h0);
        cyc(8'hFF);
        chk("rel_e6_lvl",  {24'h0, gin_a},  32'hFF);
        chk("rel_e6_rise", {24'h0, rise_a}, 32'hFF);
        cyc(8'hFF);
        chk("rel_e7_rise", {24'h0, rise_a}, 32'h0);
        repeat (40) cyc(8'h00);

        // Clean rise then fall on bit 0.
        repeat (40) cyc(8'h01);
        repeat (40) cyc(8'h00);

        // Glitch reject on bit 3: 3 high / 1 low repeated.
        for (int k = 0; k < 25; k++) begin
            repeat (3) cyc(8'h08);
            cyc(8'h00);
        end
        repeat (40) cyc(8'h00);
        chk("glitch_a3", {31'h0, gin_a[3]}, 32'h0);

        // Slow instance: 20 cycles of new level span exactly 2 ticks, 30 span 3.
        repeat (20) cyc(8'h20);
        repeat (40) cyc(8'h00);
        chk("glitch_b5", {31'h0, gin_b[5]}, 32'h0);
        repeat (30) cyc(8'h20);
        repeat (15) cyc(8'h00);
        chk("accept_b5", {31'h0, gin_b[5]}, 32'h1);
        repeat (40) cyc(8'h00);

        // Simultaneous channels.
        repeat (40) cyc(8'hA5);
        repeat (40) cyc(8'h5A);
        repeat (40) cyc(8'h00);

        // Random holds.
        for (int k = 0; k < 40; k++) begin
            v    = 8'($urandom);
            hold = $urandom_range(1, 40);
            repeat (hold) cyc(v);
        end

        // Noisy pads: sparse random bit flips.
        v = 8'h00;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) v = v ^ (8'h01 << $urandom_range(0, 7));
            cyc(v);
        end
        repeat (40) cyc(8'h00);

        // Reset on edge 4 of a bit-0 rise discards the partial qualification.
        repeat (3) cyc(8'h01);
        @(posedge clk_sys_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk_sys_i);
        #1;
        rst_n_i    = 1'b1;
        pulses     = 0;
        pulse_edge = 0;
        for (int e = 1; e <= 10; e++) begin
            cyc(8'h01);
            if (rise_a[0]) begin
                pulses++;
                pulse_edge = e;
            end
        end
        chk("midrst_pulses", 32'(pulses), 32'd1);
        chk("midrst_edge",   32'(pulse_edge), 32'd6);
        repeat (40) cyc(8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Input-conditioning stage for the GPIO block. It sits between the raw GPIO pads and the GPIO controller's `gpio_in_i` input. Each of the WIDTH pad inputs is synchronised into `clk_sys_i` and debounced on a prescaled sample tick. The block then presents a clean, registered level per bit and single-cycle rise/fall event pulses for interrupt or edge-capture logic.

## Interface
- `WIDTH`, 8: number of channels.
- `PRESCALE`, 100: clock cycles per sample tick; legal range ≥ 1; 1 means a tick every cycle.
- `STABLE_TICKS`, 4: number of consecutive ticks on which a changed level must be seen before it is accepted; legal range ≥ 1.
- `clk_sys_i` in 1: system clock; all logic on the rising edge.
- `rst_n_i` in 1: reset; asynchronous, active-low.
- `gpio_pad_i` in WIDTH: raw asynchronous pad levels.
- `gpio_in_o` out WIDTH: debounced level per channel; connects to the GPIO controller's `gpio_in_i`.
- `rise_o` out WIDTH: one-cycle pulse per channel on an accepted 0→1 change.
- `fall_o` out WIDTH: one-cycle pulse per channel on an accepted 1→0 change.

## Operation
- **Synchroniser:** 2-FF chain per bit (`sync1` ← pad, `sync2` ← `sync1`). No other logic reads `sync1`.
- **Prescaler:** a single counter shared by all channels, width `$clog2(PRESCALE)` (minimum 1).
  - Counts 0..PRESCALE-1, then wraps to 0.
  - `tick` is internal and is high when the counter is PRESCALE-1.
  - When PRESCALE=1, `tick` is constantly high.
- **Per-channel stability counter** `cnt[i]`, width `$clog2(STABLE_TICKS+1)`, evaluated only when `tick` is high:
  - If `sync2[i] == gpio_in_o[i]`, then `cnt[i]` ← 0.
  - Else if `cnt[i] == STABLE_TICKS-1`, then `gpio_in_o[i]` ← `sync2[i]` and `cnt[i]` ← 0. `rise_o[i]` ← `sync2[i]` and `fall_o[i]` ← `!sync2[i]`.
  - Else `cnt[i]` ← `cnt[i]` + 1.
- **Off-tick cycles:** `cnt` and `gpio_in_o` hold.
- **Pulses:** `rise_o` and `fall_o` are registered and cleared to 0 on every cycle on which they are not set by the rule above. Each pulse is therefore exactly one cycle wide and is asserted on the same edge on which `gpio_in_o` changes.
- **Glitches:**
  - Any tick on which the pad is back at the accepted level restarts the qualification from zero.
  - A glitch shorter than STABLE_TICKS consecutive ticks never reaches `gpio_in_o`.
- **Channel independence:** channels are fully independent. Simultaneous changes on several bits each qualify and pulse on their own, possibly on the same cycle.
- `rise_o[i]` and `fall_o[i]` are never high together.
- `cnt[i]` never exceeds STABLE_TICKS-1.

## Timing
- **Reset (asynchronous, `rst_n_i`=0):** all of the following clear immediately.
  - `sync1`, `sync2`, the prescaler counter and all `cnt` → 0.
  - `gpio_in_o` = 0, `rise_o` = 0, `fall_o` = 0.
- **Reset release:**
  - Prescaler starts at 0; the first tick is at the PRESCALE-th rising edge after release.
  - A pad held at 1 through reset is treated as a normal 0→1 change: `gpio_in_o` rises after full qualification and `rise_o` pulses once.
- **Reset asserted mid-qualification:** the partial count is discarded. No pulse is produced for the aborted change.
- **Latency, PRESCALE=1:** the pad change is sampled at edge 1 and reaches `sync2` at edge 2. Ticks on edges 3..STABLE_TICKS+2 qualify it. `gpio_in_o` and the pulse update on edge STABLE_TICKS+2.
- **Latency, general PRESCALE:**
  - Worst case is 2 + PRESCALE·STABLE_TICKS edges.
  - Best case is 2 + PRESCALE·(STABLE_TICKS-1) + 1 edges, depending on the prescaler phase.
- **Throughput:** a changed level can be accepted at most once per STABLE_TICKS ticks per channel.

## Test plan
- **Reset:** assert `rst_n_i`=0 with pad=8'hFF → `gpio_in_o`=0, `rise_o`=0, `fall_o`=0 immediately. Release with PRESCALE=1, STABLE_TICKS=4 → `gpio_in_o`=8'hFF on edge 6 after release, `rise_o`=8'hFF for exactly that one cycle.
- **Clean rise then fall (PRESCALE=1, STABLE_TICKS=4):**
  - Pad bit 0: 0→1 → `gpio_in_o[0]`=1 on edge 6, `rise_o[0]` pulses for 1 cycle.
  - Pad bit 0: 1→0 → `gpio_in_o[0]`=0 on edge 6, `fall_o[0]` pulses for 1 cycle.
  - No other bits toggle.
- **Glitch reject (PRESCALE=1, STABLE_TICKS=4):** pad bit 3 high for 3 cycles, then low → `gpio_in_o[3]` stays 0, no pulses. A repeated 3-high/1-low pattern for 100 cycles also produces no change.
- **Prescaler (PRESCALE=10, STABLE_TICKS=3):**
  - Ticks occur every 10th edge from reset.
  - Pad bit 5 changes right after a tick → `gpio_in_o[5]` updates on the 3rd tick at which `sync2` is new, never between ticks.
  - Holding `sync2` new for only 2 ticks → no change.
- **Simultaneous channels:** pad 8'h00→8'hA5 in one cycle → `gpio_in_o`=8'hA5 and `rise_o`=8'hA5 on the same cycle. Then 8'hA5→8'h5A → `rise_o`=8'h5A and `fall_o`=8'hA5 on the same cycle.
- **Reset mid-count:** with PRESCALE=1, STABLE_TICKS=4, assert reset on edge 4 of a pad rise → all outputs 0. After release, full 6-edge qualification is required before `rise_o` pulses, and only one pulse is produced.
